// File: rtl/seq_and_driver_if.sv
// Checker-facing bus of the sequence-AND harness: stimulus out (en, signal_1/2), responses back (match, fail).
// The driver takes the master modport; the checker under test takes the slave modport.
interface seq_and_driver_if;
  logic en;
  logic signal_1;
  logic signal_2;
  logic match;
  logic fail;

  modport master (
    output en,
    output signal_1,
    output signal_2,
    input  match,
    input  fail
  );

  modport slave (
    input  en,
    input  signal_1,
    input  signal_2,
    output match,
    output fail
  );
endinterface : seq_and_driver_if

// File: rtl/seq_and_driver.sv
// Stimulus/scoring harness for a sequence-AND checker: drives one programmed run, collects sticky
// match/fail responses and keeps run/error statistics. Define SEQ_AND_DRIVER_LASTERR_EN to add last_err.
module seq_and_driver #(
  parameter int WINDOW  = 5,
  parameter int OBS_CYC = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WINDOW-1:0] pat_1,
  input  logic [WINDOW-1:0] pat_2,
  input  logic              exp_match,
  input  logic              exp_fail,
  seq_and_driver_if.master  chk,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  run_cnt,
  output logic [CNT_W-1:0]  err_cnt
`ifdef SEQ_AND_DRIVER_LASTERR_EN
  ,
  output logic [1:0]        last_err
`endif
);

  localparam int IDX_W = (WINDOW  > 1) ? $clog2(WINDOW)  : 1;
  localparam int OBS_W = (OBS_CYC > 1) ? $clog2(OBS_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic [OBS_W-1:0] LAST_OBS = OBS_W'(OBS_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_OBSERVE,
    S_CHECK
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [OBS_W-1:0]  obs_q, obs_d;
  logic              seen_match_q, seen_match_d;
  logic              seen_fail_q, seen_fail_d;
  logic              en_q, en_d;
  logic              sig1_q, sig1_d;
  logic              sig2_q, sig2_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Run configuration captured at start; only read while busy.
  logic [WINDOW-1:0] pat1_q, pat1_d;
  logic [WINDOW-1:0] pat2_q, pat2_d;
  logic              exp_match_q, exp_match_d;
  logic              exp_fail_q, exp_fail_d;

  logic              match_ok;
  logic              fail_ok;

`ifdef SEQ_AND_DRIVER_LASTERR_EN
  logic [1:0]        last_err_q, last_err_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    obs_d        = obs_q;
    seen_match_d = seen_match_q;
    seen_fail_d  = seen_fail_q;
    pass_d       = pass_q;
    run_cnt_d    = run_cnt_q;
    err_cnt_d    = err_cnt_q;
    pat1_d       = pat1_q;
    pat2_d       = pat2_q;
    exp_match_d  = exp_match_q;
    exp_fail_d   = exp_fail_q;
    en_d         = 1'b0;
    sig1_d       = 1'b0;
    sig2_d       = 1'b0;
    done_d       = 1'b0;
    idx_nxt      = idx_q + 1'b1;
    match_ok     = (seen_match_q == exp_match_q);
    fail_ok      = (seen_fail_q  == exp_fail_q);
`ifdef SEQ_AND_DRIVER_LASTERR_EN
    last_err_d   = last_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat1_d       = pat_1;
          pat2_d       = pat_2;
          exp_match_d  = exp_match;
          exp_fail_d   = exp_fail;
          seen_match_d = 1'b0;
          seen_fail_d  = 1'b0;
          idx_d        = '0;
          en_d         = 1'b1;
          sig1_d       = pat_1[0];
          sig2_d       = pat_2[0];
          state_d      = S_DRIVE;
        end
      end

      S_DRIVE: begin
        seen_match_d = seen_match_q | chk.match;
        seen_fail_d  = seen_fail_q  | chk.fail;
        if (idx_q == LAST_IDX) begin
          obs_d   = '0;
          state_d = S_OBSERVE;
        end else begin
          idx_d  = idx_nxt;
          sig1_d = pat1_q[idx_nxt];
          sig2_d = pat2_q[idx_nxt];
        end
      end

      S_OBSERVE: begin
        seen_match_d = seen_match_q | chk.match;
        seen_fail_d  = seen_fail_q  | chk.fail;
        if (obs_q == LAST_OBS) begin
          state_d = S_CHECK;
        end else begin
          obs_d = obs_q + 1'b1;
        end
      end

      S_CHECK: begin
        pass_d  = match_ok && fail_ok;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (run_cnt_q != CNT_MAX) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
        if (!(match_ok && fail_ok) && (err_cnt_q != CNT_MAX)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
`ifdef SEQ_AND_DRIVER_LASTERR_EN
        if (!(match_ok && fail_ok)) begin
          last_err_d = {!fail_ok, !match_ok};
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and status state; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      obs_q        <= '0;
      seen_match_q <= 1'b0;
      seen_fail_q  <= 1'b0;
      en_q         <= 1'b0;
      sig1_q       <= 1'b0;
      sig2_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      run_cnt_q    <= '0;
      err_cnt_q    <= '0;
`ifdef SEQ_AND_DRIVER_LASTERR_EN
      last_err_q   <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      obs_q        <= obs_d;
      seen_match_q <= seen_match_d;
      seen_fail_q  <= seen_fail_d;
      en_q         <= en_d;
      sig1_q       <= sig1_d;
      sig2_q       <= sig2_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      run_cnt_q    <= run_cnt_d;
      err_cnt_q    <= err_cnt_d;
`ifdef SEQ_AND_DRIVER_LASTERR_EN
      last_err_q   <= last_err_d;
`endif
    end
  end

  // NOTE: the run configuration is left unreset; it is always loaded at start before anything reads it.
  always_ff @(posedge clk) begin
    pat1_q      <= pat1_d;
    pat2_q      <= pat2_d;
    exp_match_q <= exp_match_d;
    exp_fail_q  <= exp_fail_d;
  end

  assign chk.en       = en_q;
  assign chk.signal_1 = sig1_q;
  assign chk.signal_2 = sig2_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign pass         = pass_q;
  assign run_cnt      = run_cnt_q;
  assign err_cnt      = err_cnt_q;
`ifdef SEQ_AND_DRIVER_LASTERR_EN
  assign last_err     = last_err_q;
`endif

endmodule : seq_and_driver

// File: tb/tb_seq_and_driver.sv
// Directed bench for seq_and_driver: a vector table of whole runs plus hand sequences for
// mid-run reset and counter saturation (second instance with CNT_W=2).
module tb_seq_and_driver;

  localparam int WINDOW  = 5;
  localparam int OBS_CYC = 4;
  localparam int DONE_K  = WINDOW + OBS_CYC + 1;  // cycle offset of done relative to en

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic              start2;
  logic [WINDOW-1:0] pat_1;
  logic [WINDOW-1:0] pat_2;
  logic              exp_match;
  logic              exp_fail;

  logic              busy, done, pass;
  logic [7:0]        run_cnt, err_cnt;
  logic              busy2, done2, pass2;
  logic [1:0]        run_cnt2, err_cnt2;
`ifdef SEQ_AND_DRIVER_LASTERR_EN
  logic [1:0]        last_err, last_err2;
`endif

  seq_and_driver_if chk_if ();
  seq_and_driver_if chk2_if ();

  seq_and_driver #(.WINDOW(WINDOW), .OBS_CYC(OBS_CYC), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pat_1     (pat_1),
    .pat_2     (pat_2),
    .exp_match (exp_match),
    .exp_fail  (exp_fail),
    .chk       (chk_if),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .run_cnt   (run_cnt),
    .err_cnt   (err_cnt)
`ifdef SEQ_AND_DRIVER_LASTERR_EN
    ,
    .last_err  (last_err)
`endif
  );

  seq_and_driver #(.WINDOW(WINDOW), .OBS_CYC(OBS_CYC), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .pat_1     (pat_1),
    .pat_2     (pat_2),
    .exp_match (exp_match),
    .exp_fail  (exp_fail),
    .chk       (chk2_if),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .run_cnt   (run_cnt2),
    .err_cnt   (err_cnt2)
`ifdef SEQ_AND_DRIVER_LASTERR_EN
    ,
    .last_err  (last_err2)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  typedef struct {
    string             name;
    logic [WINDOW-1:0] p1;
    logic [WINDOW-1:0] p2;
    logic              em;
    logic              ef;
    int                match_k;    // offset from en at which match pulses (-1: never)
    int                fail_k;
    int                restart_k;  // offset at which a second start is attempted (-1: never)
    logic [WINDOW-1:0] alt1;
    logic [WINDOW-1:0] alt2;
    logic              exp_pass;
    int                exp_run;
    int                exp_err;
    logic [1:0]        exp_last_err;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [WINDOW-1:0] p1, input logic [WINDOW-1:0] p2,
                              input logic em, input logic ef, input int mk_k, input int fk_k,
                              input int rk, input logic [WINDOW-1:0] a1, input logic [WINDOW-1:0] a2,
                              input logic ep, input int er, input int ee, input logic [1:0] el);
    vec_t v;
    v.name = name; v.p1 = p1; v.p2 = p2; v.em = em; v.ef = ef;
    v.match_k = mk_k; v.fail_k = fk_k; v.restart_k = rk; v.alt1 = a1; v.alt2 = a2;
    v.exp_pass = ep; v.exp_run = er; v.exp_err = ee; v.exp_last_err = el;
    return v;
  endfunction

  // Caller is positioned at a falling edge; start is raised there (cycle T), en expected at T+1.
  task automatic run_vec(input vec_t v);
    pat_1 = v.p1; pat_2 = v.p2; exp_match = v.em; exp_fail = v.ef;
    start = 1'b1;
    for (int k = 0; k <= DONE_K; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == v.restart_k) begin
        start = 1'b1; pat_1 = v.alt1; pat_2 = v.alt2; exp_match = ~v.em; exp_fail = ~v.ef;
      end
      chk_if.match = (k == v.match_k);
      chk_if.fail  = (k == v.fail_k);
      check($sformatf("%s k%0d en", v.name, k), 32'(chk_if.en), 32'(k == 0));
      check($sformatf("%s k%0d sig1", v.name, k), 32'(chk_if.signal_1), 32'((k < WINDOW) ? v.p1[k] : 1'b0));
      check($sformatf("%s k%0d sig2", v.name, k), 32'(chk_if.signal_2), 32'((k < WINDOW) ? v.p2[k] : 1'b0));
      check($sformatf("%s k%0d busy", v.name, k), 32'(busy), 32'(k < DONE_K));
      check($sformatf("%s k%0d done", v.name, k), 32'(done), 32'(k == DONE_K));
    end
    check({v.name, " pass"}, 32'(pass), 32'(v.exp_pass));
    check({v.name, " run_cnt"}, 32'(run_cnt), 32'(v.exp_run));
    check({v.name, " err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
`ifdef SEQ_AND_DRIVER_LASTERR_EN
    check({v.name, " last_err"}, 32'(last_err), 32'(v.exp_last_err));
`endif
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mk("all_ones_match",  5'b11111, 5'b11111, 1, 0,  2, -1, -1, '0, '0, 1, 1, 0, 2'b00);
    vecs[1] = mk("fail_in_observe", 5'b00000, 5'b11111, 0, 1, -1,  6, -1, '0, '0, 1, 2, 0, 2'b00);
    vecs[2] = mk("missing_fail",    5'b00000, 5'b11111, 0, 1, -1, -1, -1, '0, '0, 0, 3, 1, 2'b10);
    vecs[3] = mk("match_last_obs",  5'b10110, 5'b01101, 1, 0,  8, -1, -1, '0, '0, 1, 4, 1, 2'b10);
    vecs[4] = mk("match_in_check",  5'b01001, 5'b10010, 1, 0,  9, -1, -1, '0, '0, 0, 5, 2, 2'b01);
    vecs[5] = mk("both_unexpected", 5'b11000, 5'b00011, 0, 0,  0,  4, -1, '0, '0, 0, 6, 3, 2'b11);
    vecs[6] = mk("both_expected",   5'b11000, 5'b00011, 1, 1,  0,  4, -1, '0, '0, 1, 7, 3, 2'b11);
    vecs[7] = mk("restart_drive",   5'b10101, 5'b00011, 0, 0, -1, -1,  2, 5'b01010, 5'b11100, 1, 8, 3, 2'b11);
    vecs[8] = mk("restart_check",   5'b01110, 5'b10001, 0, 0, -1, -1,  9, 5'b10001, 5'b01110, 1, 9, 3, 2'b11);

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    pat_1 = '0; pat_2 = '0; exp_match = 1'b0; exp_fail = 1'b0;
    chk_if.match = 1'b0; chk_if.fail = 1'b0;
    chk2_if.match = 1'b0; chk2_if.fail = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then 5 idle cycles with nothing driven.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("idle c%0d outputs", c),
            32'({chk_if.en, chk_if.signal_1, chk_if.signal_2, busy, done, pass}), 32'd0);
    end
    check("idle run_cnt", 32'(run_cnt), 32'd0);
    check("idle err_cnt", 32'(err_cnt), 32'd0);
`ifdef SEQ_AND_DRIVER_LASTERR_EN
    check("idle last_err", 32'(last_err), 32'd0);
`endif

    // Table runs are issued back-to-back: each new start lands in the previous run's done cycle.
    foreach (vecs[i]) run_vec(vecs[i]);

    // A single done per run: nothing follows the last one.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("after_table c%0d done", c), 32'(done), 32'd0);
      check($sformatf("after_table c%0d busy", c), 32'(busy), 32'd0);
    end

    // Reset in the middle of OBSERVE aborts the run.
    pat_1 = 5'b11111; pat_2 = 5'b00000; exp_match = 1'b0; exp_fail = 1'b0;
    start = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort outputs", 32'({chk_if.en, chk_if.signal_1, chk_if.signal_2, busy, done, pass}), 32'd0);
    check("abort run_cnt", 32'(run_cnt), 32'd0);
    check("abort err_cnt", 32'(err_cnt), 32'd0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int c = 0; c < DONE_K + 2; c++) begin
        @(negedge clk);
        saw_done |= done;
      end
      check("abort no_done", 32'(saw_done), 32'd0);
    end

    // Saturation on the CNT_W=2 instance: five failing runs.
    pat_1 = 5'b10011; pat_2 = 5'b01100; exp_match = 1'b1; exp_fail = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      start2 = 1'b1;
      for (int k = 0; k <= DONE_K; k++) begin
        @(negedge clk);
        start2 = 1'b0;
      end
      check($sformatf("sat run%0d done", n), 32'(done2), 32'd1);
      check($sformatf("sat run%0d pass", n), 32'(pass2), 32'd0);
      check($sformatf("sat run%0d run_cnt", n), 32'(run_cnt2), 32'((n > 3) ? 3 : n));
      check($sformatf("sat run%0d err_cnt", n), 32'(err_cnt2), 32'((n > 3) ? 3 : n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_and_driver
